// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, single-outstanding imem fetch, 2-entry instruction buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    typedef enum logic {FETCH, WAIT} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, req_pc;
    logic        drop, drop_n;
    logic [1:0]  count, count_n;
    logic [31:0] fifo_pc [2];
    logic [31:0] fifo_word [2];
    logic        rd_ptr, wr_ptr;
    logic        gnt, rsp, push, pop;

    assign imem_req   = state == FETCH && count != 2'd2 && !rst;
    assign imem_addr  = pc;
    assign gnt        = imem_req && imem_gnt;
    assign rsp        = state == WAIT && imem_rvalid;
    assign push       = rsp && !drop && !redirect;
    assign inst_valid = count != 2'd0 && !rst;
    assign pop        = inst_valid && inst_ready;
    assign inst       = fifo_word[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];

    // next state: a redirect keeps WAIT (and marks the response for dropping) while one is still owed
    always_comb begin
        state_n = state;
        drop_n  = drop;
        pc_n    = pc;
        count_n = count + {1'b0, push} - {1'b0, pop};
        if (redirect) begin
            pc_n    = redirect_pc & 32'hFFFF_FFFC;
            count_n = 2'd0;
            state_n = ((state == WAIT && !imem_rvalid) || gnt) ? WAIT : FETCH;
            drop_n  = state_n == WAIT;
        end else if (gnt) begin
            pc_n    = pc + 32'd4;
            state_n = WAIT;
        end else if (rsp) begin
            state_n = FETCH;
            drop_n  = 1'b0;
        end
    end

    // control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            drop   <= 1'b0;
            count  <= 2'd0;
            req_pc <= 32'd0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            drop   <= drop_n;
            count  <= count_n;
            req_pc <= gnt ? pc : req_pc;
        end
    end

    // instruction buffer storage; a redirect empties it by realigning both pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_pc[0]   <= 32'd0;
            fifo_pc[1]   <= 32'd0;
            fifo_word[0] <= 32'd0;
            fifo_word[1] <= 32'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
        end else if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= req_pc;
                fifo_word[wr_ptr] <= imem_rdata;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decoder environment with an in-order PC scoreboard
module tb_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, redirect = 1'b0, inst_ready = 1'b1;
    logic [31:0] imem_rdata = 32'd0, redirect_pc = 32'd0;

    logic        req1, valid1;
    logic [31:0] addr1, inst1, pc1;
    logic        gnt1 = 1'b1, rv1 = 1'b0, red1 = 1'b0, ready1 = 1'b1;
    logic [31:0] rd1 = 32'd0, rpc1 = 32'd0;

    int          nchecks = 0, nerr = 0, ndel = 0;
    logic [31:0] exp_pc = 32'd0, last_pc = 32'd0, mem_addr = 32'd0, hold_addr = 32'd0;
    logic        busy = 1'b0, hold_pend = 1'b0;
    int          wait_cnt = 0, gnt_pct = 100, lat_min = 1, lat_max = 1;
    logic [31:0] q1 [$];

    fetch_unit u0 (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt1),
        .imem_rvalid(rv1), .imem_rdata(rd1), .redirect(red1), .redirect_pc(rpc1),
        .inst_valid(valid1), .inst_ready(ready1), .inst(inst1), .inst_pc(pc1)
    );

    always #5 clk = ~clk;

    // one clock: score consumes, advance, then update memory model and drive next inputs
    task automatic tick();
        logic fire, rv, red, r, fire1;
        logic [31:0] a, a1, rpc;
        if (!rst && hold_pend) begin
            nchecks++;
            if (imem_req !== 1'b1 || imem_addr !== hold_addr) begin
                nerr++;
                $display("FAIL hold: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, hold_addr);
            end
        end
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            nchecks++;
            if (inst_pc !== exp_pc || inst !== (exp_pc ^ K)) begin
                nerr++;
                $display("FAIL deliver: inst_pc=%h inst=%h required inst_pc=%h inst=%h", inst_pc, inst, exp_pc, exp_pc ^ K);
            end
            last_pc = inst_pc;
            ndel++;
            exp_pc = exp_pc + 32'd4;
        end
        if (valid1 === 1'b1) begin
            q1.push_back(pc1);
            nchecks++;
            if (inst1 !== (pc1 ^ K)) begin
                nerr++;
                $display("FAIL deliver1: inst=%h required %h", inst1, pc1 ^ K);
            end
        end
        fire = imem_req && imem_gnt;
        a = imem_addr;
        rv = imem_rvalid;
        red = redirect;
        rpc = redirect_pc;
        r = rst;
        hold_pend = imem_req && !imem_gnt && !redirect && !rst;
        hold_addr = imem_addr;
        fire1 = req1;
        a1 = addr1;
        @(posedge clk);
        #1;
        if (r) begin
            exp_pc = 32'd0;
            hold_pend = 1'b0;
        end else if (red) begin
            exp_pc = rpc & 32'hFFFF_FFFC;
            nchecks++;
            if (inst_valid !== 1'b0) begin
                nerr++;
                $display("FAIL redirect_flush: inst_valid=%b required 0", inst_valid);
            end
        end
        if (rv) busy = 1'b0;
        if (fire) begin
            busy = 1'b1;
            mem_addr = a;
            wait_cnt = int'($urandom_range(lat_max, lat_min));
        end
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        if (busy) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_addr ^ K;
            end
        end
        imem_gnt = !busy && (int'($urandom_range(99)) < gnt_pct);
        redirect = 1'b0;
        rv1 = fire1;
        rd1 = a1 ^ K;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        nchecks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ctl: req=%b valid=%b required 0 0", imem_req, inst_valid);
        end
        nchecks++;
        if (inst !== 32'd0 || inst_pc !== 32'd0) begin
            nerr++;
            $display("FAIL reset_data: inst=%h inst_pc=%h required 0 0", inst, inst_pc);
        end
        rst = 1'b0;
        #1;
        nchecks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            nerr++;
            $display("FAIL first_req: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
        nchecks++;
        if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFF8) begin
            nerr++;
            $display("FAIL first_req1: req=%b addr=%h required 1 fffffff8", req1, addr1);
        end
    endtask

    task automatic test_stream();
        int n = 0;
        int d0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; inst_ready = 1'b1;
        do_reset();
        d0 = ndel;
        while (inst_valid !== 1'b1 && n < 20) begin tick(); n++; end
        for (int i = 0; i < 8; i++) begin
            nchecks++;
            if (inst_valid !== (i % 2 == 0)) begin
                nerr++;
                $display("FAIL stream_rate: step %0d valid=%b required %b", i, inst_valid, i % 2 == 0);
            end
            tick();
        end
        nchecks++;
        if (ndel != d0 + 4 || last_pc !== 32'hC) begin
            nerr++;
            $display("FAIL stream_count: delivered=%0d last=%h required 4 0000000c", ndel - d0, last_pc);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int d0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        inst_ready = 1'b0;
        repeat (10) tick();
        nchecks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst_pc !== 32'd0) begin
            nerr++;
            $display("FAIL bp_full: valid=%b req=%b pc=%h required 1 0 00000000", inst_valid, imem_req, inst_pc);
        end
        d0 = ndel;
        inst_ready = 1'b1;
        tick();
        nchecks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'd4) begin
            nerr++;
            $display("FAIL bp_second: valid=%b pc=%h required 1 00000004", inst_valid, inst_pc);
        end
        while (ndel < d0 + 3 && n < 30) begin tick(); n++; end
        nchecks++;
        if (ndel != d0 + 3 || last_pc !== 32'h8) begin
            nerr++;
            $display("FAIL bp_release: delivered=%0d last=%h required 3 00000008", ndel - d0, last_pc);
        end
    endtask

    task automatic test_redirect_outstanding();
        int n = 0;
        int d0;
        gnt_pct = 100; lat_min = 3; lat_max = 3; inst_ready = 1'b1;
        do_reset();
        while (!(imem_req && imem_gnt && imem_addr == 32'h8) && n < 40) begin tick(); n++; end
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        nchecks++;
        if (imem_req !== 1'b0) begin
            nerr++;
            $display("FAIL redir_out_wait: req=%b required 0", imem_req);
        end
        d0 = ndel;
        n = 0;
        while (ndel == d0 && n < 40) begin tick(); n++; end
        nchecks++;
        if (ndel == d0 || last_pc !== 32'h100) begin
            nerr++;
            $display("FAIL redir_out_target: last=%h required 00000100", last_pc);
        end
    endtask

    task automatic test_redirect_rvalid();
        int n = 0;
        int d0;
        gnt_pct = 100; lat_min = 2; lat_max = 2; inst_ready = 1'b1;
        do_reset();
        while (!(imem_rvalid && mem_addr == 32'h4) && n < 40) begin tick(); n++; end
        redirect = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick();
        nchecks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
            nerr++;
            $display("FAIL redir_rv_req: req=%b addr=%h required 1 00002000", imem_req, imem_addr);
        end
        d0 = ndel;
        n = 0;
        while (ndel == d0 && n < 40) begin tick(); n++; end
        nchecks++;
        if (ndel == d0 || last_pc !== 32'h2000) begin
            nerr++;
            $display("FAIL redir_rv_target: last=%h required 00002000", last_pc);
        end
    endtask

    task automatic test_redirect_gnt();
        int n = 0;
        int d0;
        gnt_pct = 100; lat_min = 1; lat_max = 1; inst_ready = 1'b1;
        do_reset();
        while (!(imem_req && imem_gnt && imem_addr == 32'h4) && n < 40) begin tick(); n++; end
        redirect = 1'b1;
        redirect_pc = 32'h0000_3002;
        tick();
        nchecks++;
        if (imem_req !== 1'b0) begin
            nerr++;
            $display("FAIL redir_gnt_wait: req=%b required 0", imem_req);
        end
        d0 = ndel;
        n = 0;
        while (ndel == d0 && n < 40) begin tick(); n++; end
        nchecks++;
        if (ndel == d0 || last_pc !== 32'h3000) begin
            nerr++;
            $display("FAIL redir_gnt_target: last=%h required 00003000", last_pc);
        end
    endtask

    task automatic test_reset_pc();
        int n = 0;
        logic [31:0] p0, p1, p2;
        do_reset();
        q1.delete();
        while (q1.size() < 3 && n < 30) begin tick(); n++; end
        p0 = q1.size() > 0 ? q1[0] : 32'hDEAD_DEAD;
        p1 = q1.size() > 1 ? q1[1] : 32'hDEAD_DEAD;
        p2 = q1.size() > 2 ? q1[2] : 32'hDEAD_DEAD;
        nchecks++;
        if (p0 !== 32'hFFFF_FFF8 || p1 !== 32'hFFFF_FFFC || p2 !== 32'h0) begin
            nerr++;
            $display("FAIL wrap_seq: got %h %h %h required fffffff8 fffffffc 00000000", p0, p1, p2);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int d0;
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        do_reset();
        inst_ready = 1'b0;
        while (!(imem_req && imem_gnt && imem_addr == 32'h4) && n < 40) begin tick(); n++; end
        tick();
        nchecks++;
        if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin
            nerr++;
            $display("FAIL mid_pre: valid=%b req=%b required 1 0", inst_valid, imem_req);
        end
        rst = 1'b1;
        tick();
        nchecks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            nerr++;
            $display("FAIL mid_reset: valid=%b req=%b required 0 0", inst_valid, imem_req);
        end
        rst = 1'b0;
        #1;
        nchecks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            nerr++;
            $display("FAIL mid_first_req: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
        inst_ready = 1'b1;
        d0 = ndel;
        n = 0;
        while (ndel == d0 && n < 40) begin tick(); n++; end
        nchecks++;
        if (ndel == d0 || last_pc !== 32'd0) begin
            nerr++;
            $display("FAIL mid_after: last=%h required 00000000", last_pc);
        end
    endtask

    task automatic test_random();
        int d0;
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        do_reset();
        d0 = ndel;
        for (int i = 0; i < 3000; i++) begin
            inst_ready = $urandom_range(99) < 70;
            if ($urandom_range(99) < 3) begin
                redirect = 1'b1;
                redirect_pc = $urandom;
            end
            tick();
        end
        nchecks++;
        if (ndel - d0 < 200) begin
            nerr++;
            $display("FAIL random_progress: delivered=%0d required at least 200", ndel - d0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_rvalid();
        test_redirect_gnt();
        test_reset_pc();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
